// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path: opcode values,
// ALU-control codes, datapath select encodings, the main-control state
// enum and the registered Moore control word with its per-state decode.
// Used by mips_main_control, the ALU-control decoder and the datapath.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Supported opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // alu_op codes consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    // alu_src_b select encodings
    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    // pc_source select encodings
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_INIT, S_FETCH, S_DECODE,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB,
        S_BRANCH, S_JUMP,
        S_I_EXEC, S_I_WB
    } state_t;

    // Moore part of the control word. ir_write and the FETCH pc_write are
    // Mealy on mem_ack and are added outside the register.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI) ||
               (op == OP_ANDI);
    endfunction

    // Control word asserted while the FSM sits in state s; op is the
    // latched opcode (only I_EXEC looks at it).
    function automatic ctrl_t moore_decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SHL2;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
                c.retire    = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = (op == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_perf_counters.sv
// ---------------------------------------------------------------------------
// mips_perf_counters
// Free-running cycle and retired-instruction counters for the main control
// FSM. Only instantiated when MIPS_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   active       count this cycle (FSM has left INIT)
//   retire       instruction retired this cycle
//   cycle_cnt    cycles since INIT, wraps modulo 2^PERF_W
//   retired_cnt  retired instructions, wraps modulo 2^PERF_W
// ---------------------------------------------------------------------------
module mips_perf_counters #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              retire,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retired_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (active) begin
                cycle_cnt <= cycle_cnt + PERF_W'(1);
            end
            if (retire) begin
                retired_cnt <= retired_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: rtl/mips_main_control.sv
// ---------------------------------------------------------------------------
// mips_main_control
// Multicycle main-control FSM for the MIPS datapath. Sequences
// FETCH/DECODE/execute/writeback per opcode and drives every datapath
// enable and select. Memory accesses hold mem_read/mem_write until mem_ack.
// Optional feature macro: MIPS_PERF_CNT_EN adds cycle_cnt / retired_cnt.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   opcode[5:0]                     IR[31:26], sampled in DECODE
//   mem_ack                         memory completes the current access
//   zero                            ALU zero flag (gated in the datapath)
//   pc_write, pc_write_cond,
//   pc_source[1:0], i_or_d,
//   mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write,
//   alu_src_a, alu_src_b[1:0],
//   alu_op[1:0]                     datapath controls
//   instr_retired                   pulse on last cycle of a legal instr
//   illegal_op                      pulse in DECODE for unsupported opcode
//   cycle_cnt, retired_cnt          (MIPS_PERF_CNT_EN only) counters
// ---------------------------------------------------------------------------
module mips_main_control
    import mips_ctrl_pkg::*;
#(
`ifdef MIPS_PERF_CNT_EN
    parameter int PERF_W  = 32,
`endif
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              mem_ack,
    input  logic              zero,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_source,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              mem_to_reg,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              instr_retired,
`ifdef MIPS_PERF_CNT_EN
    output logic              illegal_op,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retired_cnt
`else
    output logic              illegal_op
`endif
);

    if (STATE_W < STATE_BITS) begin : g_state_w_too_small
        $error("STATE_W too small to encode all main-control states");
    end

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] opcode_reg;
    logic [5:0] decode_op;
    ctrl_t      ctrl_reg;
    logic       fetch_ack;

    // The branch decision is made in the datapath; the flag is carried on
    // this port only so the control/datapath interface stays in one place.
    logic unused_zero;
    assign unused_zero = zero;

    // In DECODE the opcode is being latched this cycle, so the control word
    // for the following state is built from the live value.
    assign decode_op = (state_reg == S_DECODE) ? opcode : opcode_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:      state_next = S_FETCH;
            S_FETCH:     if (mem_ack) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_next = S_MEM_ADDR;
                    OP_RTYPE:         state_next = S_R_EXEC;
                    OP_BEQ:           state_next = S_BRANCH;
                    OP_J:             state_next = S_JUMP;
                    OP_ADDI, OP_ANDI: state_next = S_I_EXEC;
                    default:          state_next = S_FETCH;  // PC already advanced
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ack) state_next = S_MEM_WB;
            S_MEM_WRITE: if (mem_ack) state_next = S_FETCH;
            S_R_EXEC:    state_next = S_R_WB;
            S_I_EXEC:    state_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB:
                         state_next = S_FETCH;
            default:     state_next = S_INIT;
        endcase
    end

    // Moore outputs are registered alongside the state, so they equal the
    // decode of the state they accompany.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_INIT;
            opcode_reg <= '0;
            ctrl_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_reg <= opcode;
            end
            ctrl_reg <= moore_decode(state_next, decode_op);
        end
    end

    assign fetch_ack = (state_reg == S_FETCH) && mem_ack;

    assign pc_write      = ctrl_reg.pc_write | fetch_ack;
    assign ir_write      = fetch_ack;
    assign pc_write_cond = ctrl_reg.pc_write_cond;
    assign pc_source     = ctrl_reg.pc_source;
    assign i_or_d        = ctrl_reg.i_or_d;
    assign mem_read      = ctrl_reg.mem_read;
    assign mem_write     = ctrl_reg.mem_write;
    assign mem_to_reg    = ctrl_reg.mem_to_reg;
    assign reg_dst       = ctrl_reg.reg_dst;
    assign reg_write     = ctrl_reg.reg_write;
    assign alu_src_a     = ctrl_reg.alu_src_a;
    assign alu_src_b     = ctrl_reg.alu_src_b;
    assign alu_op        = ctrl_reg.alu_op;
    // A store's last cycle is the one where its write is acknowledged.
    assign instr_retired = ctrl_reg.retire | ((state_reg == S_MEM_WRITE) && mem_ack);
    assign illegal_op    = (state_reg == S_DECODE) && !is_legal(opcode);

`ifdef MIPS_PERF_CNT_EN
    mips_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf_counters (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (state_reg != S_INIT),
        .retire      (instr_retired),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );
`endif

endmodule
